load_store_unit: RTL

- Downstream of the ALU: takes the ALU-computed effective address and runs one data-memory access per request.
- Handles RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW): byte-lane steering, write strobes, load extraction and sign extension.
- Detects misaligned and illegal accesses and times out a memory that never acknowledges.
- Delivers a one-cycle result pulse to writeback. One request in flight at a time.

---
 rtl/load_store_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit sitting after the ALU.
// Takes one load/store request at a time and checks it for an illegal funct3
// or a misaligned address. Legal requests drive a single memory access with
// byte-lane steering, and the result goes to writeback as a one-cycle pulse.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         request handshake (ready only while IDLE)
//   in_addr/in_wdata          effective address, store data (rs2)
//   in_funct3/in_is_store     access size/sign, load vs store
//   in_rd                     load destination register
//   mem_req/mem_we/mem_addr   memory request, held until ack or timeout
//   mem_wdata/mem_wstrb       lane-replicated store data, byte strobes
//   mem_ack/mem_rdata         completion and read word
//   out_valid/out_rd          result pulse and destination (0 for stores/errors)
//   out_data/out_error        extended load data; 00 ok 01 misaligned 10 timeout 11 illegal

// One byte lane of the store path: picks the byte this lane carries and
// whether its strobe fires for the registered size/offset.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b_byte,   // byte 0 of store data (SB replicates it)
  input  logic [7:0] h_byte,   // byte of the halfword that lands on this lane
  input  logic [7:0] w_byte,   // byte LANE of the store word
  output logic [7:0] lane_byte,
  output logic       lane_strb
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    lane_byte = w_byte;
    lane_strb = 1'b1;
    case (size)
      2'b00: begin
        lane_byte = b_byte;
        lane_strb = (off == L);
      end
      2'b01: begin
        lane_byte = h_byte;
        // Halfword offset is 0 or 2 once alignment has been checked.
        lane_strb = (off[1] == L[1]);
      end
      default: begin
        lane_byte = w_byte;
        lane_strb = 1'b1;
      end
    endcase
  end
endmodule

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_store,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic [1:0]  out_error
);
  localparam int NUM_LANES = 4;
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  // Wraps when the timeout is disabled; TO_EN masks it in that case.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;

  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [4:0]  rd_q;
  logic [1:0]  err_q, err_nx;
  logic [15:0] cnt;

  logic in_illegal, in_misal, acc, to_hit;

  always_comb begin
    in_illegal = in_is_store ? (in_funct3 >= 3'd3)
                             : (in_funct3 == 3'd3 || in_funct3[2:1] == 2'b11);
    in_misal   = (in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                 (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
  end

  assign acc    = in_valid && (state == IDLE);
  assign to_hit = TO_EN && (cnt == TO_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: if (in_valid) begin
        if (in_illegal) begin
          state_nx = RESP;
          err_nx   = ERR_ILL;
        end else if (in_misal) begin
          state_nx = RESP;
          err_nx   = ERR_MIS;
        end else begin
          state_nx = REQ;
          err_nx   = ERR_OK;
        end
      end
      // Ack is checked first so an ack on the final allowed cycle wins.
      REQ: if (mem_ack) begin
        state_nx = RESP;
        err_nx   = ERR_OK;
      end else if (to_hit) begin
        state_nx = RESP;
        err_nx   = ERR_TO;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- request / response registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= ERR_OK;
      cnt     <= '0;
    end else begin
      err_q <= err_nx;
      if (acc) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        f3_q    <= in_funct3;
        st_q    <= in_is_store;
        rd_q    <= in_rd;
        cnt     <= '0;
      end
      if (state == REQ) begin
        if (mem_ack) rdata_q <= mem_rdata;
        else         cnt     <= cnt + 16'd1;
      end
    end
  end

  // ---------------- store lane steering ----------------
  logic [NUM_LANES-1:0][7:0] lane_wdata;
  logic [NUM_LANES-1:0]      lane_strb;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size      (f3_q[1:0]),
      .off       (addr_q[1:0]),
      .b_byte    (wdata_q[7:0]),
      .h_byte    (wdata_q[8*(i%2) +: 8]),
      .w_byte    (wdata_q[8*i +: 8]),
      .lane_byte (lane_wdata[i]),
      .lane_strb (lane_strb[i])
    );
  end

  logic in_req, in_resp, st_req;
  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);
  assign st_req  = in_req && st_q;

  assign in_ready  = (state == IDLE);
  assign mem_req   = in_req;
  assign mem_we    = st_req;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = st_req ? lane_wdata : '0;
  assign mem_wstrb = st_req ? lane_strb  : '0;

  // ---------------- load extraction ----------------
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_b = rdata_q[7:0];
      2'd1:    ld_b = rdata_q[15:8];
      2'd2:    ld_b = rdata_q[23:16];
      default: ld_b = rdata_q[31:24];
    endcase
    ld_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b010:  ld_data = rdata_q;
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = '0;
    endcase
  end

  logic ld_ok;
  assign ld_ok     = in_resp && !st_q && (err_q == ERR_OK);
  assign out_valid = in_resp;
  assign out_rd    = ld_ok ? rd_q : '0;
  assign out_data  = ld_ok ? ld_data : '0;
  assign out_error = in_resp ? err_q : ERR_OK;
endmodule
